// File: rtl/byte_unstriping_pkg.sv
// Shared definitions for the receive-side byte unstriper: default byte
// width, merge FSM state encoding and lane index constants.
package byte_unstriping_pkg;

  localparam int DATA_W_DEF = 8;

  localparam int LANE0 = 0;
  localparam int LANE1 = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane byte FIFO absorbing inter-lane skew. Status flags come from a
// registered count, so a push is never visible to a pop in the same cycle.
// A push while full is accepted only if a pop frees a slot that cycle;
// otherwise the byte is dropped and o_drop pulses.
module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_drop
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;
  assign o_dout    = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ONE_PTR;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ONE_PTR;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: storage is not reset; the pointers/count alone define which entries are live.
  always_ff @(posedge clk_2f) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/byte_unstriping.sv
// Merges two striped byte lanes back into one byte stream. Each lane is
// buffered in a lane_fifo; once both hold data the FSM enters RUN and
// emits bytes in strict lane-0 / lane-1 alternation, stalling (without
// reordering) when the selected lane is starved. After IDLE_GAP starved
// cycles with both FIFOs empty it drops back to IDLE and re-aligns on
// lane 0 when both lanes have data again.
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 4,
  parameter int IDLE_GAP = 4
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_stripe_0,
  input  logic              valid_stripe_0,
  input  logic [DATA_W-1:0] data_stripe_1,
  input  logic              valid_stripe_1,
  output logic [DATA_W-1:0] data_demux,
  output logic              valid_demux,
  output logic              aligned,
  output logic              overflow
);

  localparam int            GW       = $clog2(IDLE_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(IDLE_GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  logic [1:0]        w_pop;
  logic [1:0]        w_empty;
  logic [1:0]        w_drop;
  logic [DATA_W-1:0] w_dout [2];

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sel;
  logic              w_sel_next;
  logic [GW-1:0]     r_gap;
  logic [GW-1:0]     w_gap_next;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_next;
  logic              r_valid;
  logic              w_valid_next;
  logic              r_overflow;

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .i_push  (valid_stripe_0),
    .i_pop   (w_pop[LANE0]),
    .i_din   (data_stripe_0),
    .o_dout  (w_dout[LANE0]),
    .o_empty (w_empty[LANE0]),
    .o_full  (),
    .o_drop  (w_drop[LANE0])
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .i_push  (valid_stripe_1),
    .i_pop   (w_pop[LANE1]),
    .i_din   (data_stripe_1),
    .o_dout  (w_dout[LANE1]),
    .o_empty (w_empty[LANE1]),
    .o_full  (),
    .o_drop  (w_drop[LANE1])
  );

  // Merge FSM: next state, lane select, gap counter, pops and next output byte.
  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_gap_next   = r_gap;
    w_pop        = '0;
    w_valid_next = 1'b0;
    w_data_next  = r_data;
    case (r_state)
      ST_IDLE: begin
        w_sel_next = 1'b0;
        w_gap_next = '0;
        if (!w_empty[LANE0] && !w_empty[LANE1]) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!w_empty[r_sel]) begin
          w_pop[r_sel] = 1'b1;
          w_data_next  = w_dout[r_sel];
          w_valid_next = 1'b1;
          w_sel_next   = ~r_sel;
          w_gap_next   = '0;
        end else if ((r_gap >= GAP_LAST) && w_empty[LANE0] && w_empty[LANE1]) begin
          // This starved cycle is the IDLE_GAP-th: give up alignment.
          w_state_next = ST_IDLE;
          w_sel_next   = 1'b0;
          w_gap_next   = '0;
        end else if (r_gap != GAP_MAX) begin
          // Saturate so a long stall with data stuck in the other lane cannot wrap.
          w_gap_next = r_gap + GAP_ONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, select, gap counter and registered outputs.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sel      <= 1'b0;
      r_gap      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sel      <= w_sel_next;
      r_gap      <= w_gap_next;
      r_data     <= w_data_next;
      r_valid    <= w_valid_next;
      r_overflow <= r_overflow | (|w_drop);
    end
  end

  assign data_demux  = r_data;
  assign valid_demux = r_valid;
  assign aligned     = (r_state == ST_RUN);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_byte_unstriping.sv
// Testbench for byte_unstriping: a directed table of cycle-by-cycle vectors
// covering reset, aligned stream, skew, overflow, starvation/re-align and
// mid-stream reset, followed by randomized lane traffic checked against a
// queue-based reference model of the merge rules.
module tb_byte_unstriping;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int IDLE_GAP = 4;

  logic              clk_2f = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_stripe_0;
  logic              valid_stripe_0;
  logic [DATA_W-1:0] data_stripe_1;
  logic              valid_stripe_1;
  logic [DATA_W-1:0] data_demux;
  logic              valid_demux;
  logic              aligned;
  logic              overflow;

  always #5 clk_2f = ~clk_2f;

  byte_unstriping #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDLE_GAP(IDLE_GAP)) dut (
    .clk_2f         (clk_2f),
    .reset          (reset),
    .data_stripe_0  (data_stripe_0),
    .valid_stripe_0 (valid_stripe_0),
    .data_stripe_1  (data_stripe_1),
    .valid_stripe_1 (valid_stripe_1),
    .data_demux     (data_demux),
    .valid_demux    (valid_demux),
    .aligned        (aligned),
    .overflow       (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each lane is a queue of bytes; the merger takes from
  // the selected lane's queue as it stood before this edge's pushes.
  logic [7:0] m_q0[$];
  logic [7:0] m_q1[$];
  bit         m_run;
  bit         m_sel;
  int         m_gap;
  logic [7:0] m_data;
  bit         m_valid;
  bit         m_ovf;

  task automatic model_edge(input bit rst, input bit v0, input logic [7:0] d0,
                            input bit v1, input logic [7:0] d1);
    int n0;
    int n1;
    if (rst) begin
      m_q0.delete(); m_q1.delete();
      m_run = 0; m_sel = 0; m_gap = 0; m_data = '0; m_valid = 0; m_ovf = 0;
      return;
    end
    n0 = m_q0.size();
    n1 = m_q1.size();
    if (!m_run) begin
      m_valid = 0; m_sel = 0; m_gap = 0;
      if (n0 > 0 && n1 > 0) m_run = 1;
    end else if ((m_sel ? n1 : n0) > 0) begin
      m_data  = m_sel ? m_q1.pop_front() : m_q0.pop_front();
      m_valid = 1;
      m_sel   = !m_sel;
      m_gap   = 0;
    end else begin
      m_valid = 0;
      if (m_gap < IDLE_GAP) m_gap = m_gap + 1;
      if (m_gap >= IDLE_GAP && n0 == 0 && n1 == 0) begin
        m_run = 0; m_sel = 0; m_gap = 0;
      end
    end
    if (v0) begin
      if (m_q0.size() < DEPTH) m_q0.push_back(d0); else m_ovf = 1;
    end
    if (v1) begin
      if (m_q1.size() < DEPTH) m_q1.push_back(d1); else m_ovf = 1;
    end
  endtask

  // Apply one cycle of inputs, advance the model, and leave time 1 after the edge.
  task automatic step(input bit rst, input bit v0, input logic [7:0] d0,
                      input bit v1, input logic [7:0] d1);
    reset          = rst;
    valid_stripe_0 = v0;
    data_stripe_0  = d0;
    valid_stripe_1 = v1;
    data_stripe_1  = d1;
    @(posedge clk_2f);
    model_edge(rst, v0, d0, v1, d1);
    #1;
  endtask

  typedef struct {
    bit         rst;
    bit         v0;
    logic [7:0] d0;
    bit         v1;
    logic [7:0] d1;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_aligned;
    bit         e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit v0, logic [7:0] d0, bit v1, logic [7:0] d1,
                              bit ev, logic [7:0] ed, bit ea, bit eo);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.e_valid = ev; v.e_data = ed; v.e_aligned = ea; v.e_ovf = eo;
    vecs.push_back(v);
  endfunction

  initial begin
    // Reset held 3 cycles with both lanes pushing: nothing retained.
    for (int i = 0; i < 3; i++) add(1, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
    // Aligned stream, pushes every other cycle.
    add(0, 1, 8'h00, 1, 8'h01, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0);
    add(0, 1, 8'h02, 1, 8'h03, 1, 8'h00, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'h01, 1, 0);
    add(0, 1, 8'h04, 1, 8'h05, 1, 8'h02, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'h03, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'h04, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'h05, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h05, 0, 0);
    // Skew: lane 1 three cycles behind lane 0.
    add(0, 1, 8'hA0, 0, 8'h00, 0, 8'h05, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h05, 0, 0);
    add(0, 1, 8'hA2, 0, 8'h00, 0, 8'h05, 0, 0);
    add(0, 0, 8'h00, 1, 8'hA1, 0, 8'h05, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0);
    add(0, 0, 8'h00, 1, 8'hA3, 1, 8'hA0, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hA1, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hA2, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hA3, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 8'h00, 0, 8'hA3, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'hA3, 0, 0);
    // Overflow: five lane-0 pushes into a 4-deep FIFO, lane 1 idle.
    add(0, 1, 8'hB1, 0, 8'h00, 0, 8'hA3, 0, 0);
    add(0, 1, 8'hB2, 0, 8'h00, 0, 8'hA3, 0, 0);
    add(0, 1, 8'hB3, 0, 8'h00, 0, 8'hA3, 0, 0);
    add(0, 1, 8'hB4, 0, 8'h00, 0, 8'hA3, 0, 0);
    add(0, 1, 8'hB5, 0, 8'h00, 0, 8'hA3, 0, 1);
    add(0, 0, 8'h00, 1, 8'hC1, 0, 8'hA3, 0, 1);
    add(0, 0, 8'h00, 1, 8'hC2, 0, 8'hA3, 1, 1);
    add(0, 0, 8'h00, 1, 8'hC3, 1, 8'hB1, 1, 1);
    add(0, 0, 8'h00, 1, 8'hC4, 1, 8'hC1, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hB2, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hC2, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hB3, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hC3, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hB4, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hC4, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 8'h00, 0, 8'hC4, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'hC4, 0, 1);
    // Starvation: lane 1 silent for 6 cycles, alignment lost, re-align on lane 0.
    add(0, 1, 8'hD0, 1, 8'hD1, 0, 8'hC4, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'hC4, 1, 1);
    add(0, 1, 8'hD2, 1, 8'hD3, 1, 8'hD0, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hD1, 1, 1);
    add(0, 1, 8'hD4, 0, 8'h00, 1, 8'hD2, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hD3, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hD4, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 8'h00, 0, 8'hD4, 1, 1);
    add(0, 1, 8'hE0, 1, 8'hE1, 0, 8'hD4, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'hD4, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hE0, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'hE1, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 8'h00, 0, 8'hE1, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'hE1, 0, 1);
    // Reset mid-stream with two bytes buffered per lane.
    add(0, 1, 8'hF0, 1, 8'hF1, 0, 8'hE1, 0, 1);
    add(0, 1, 8'hF2, 1, 8'hF3, 0, 8'hE1, 1, 1);
    add(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 8'h60, 1, 8'h61, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'h60, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 8'h61, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
      check($sformatf("vec%0d valid_demux", i), 32'(valid_demux), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d data_demux", i),  32'(data_demux),  32'(vecs[i].e_data));
      check($sformatf("vec%0d aligned", i),     32'(aligned),     32'(vecs[i].e_aligned));
      check($sformatf("vec%0d overflow", i),    32'(overflow),    32'(vecs[i].e_ovf));
    end

    // Randomized traffic: per-segment push rates, occasional reset.
    step(1, 0, 8'h00, 0, 8'h00);
    for (int seg = 0; seg < 40; seg++) begin
      int p0;
      int p1;
      p0 = $urandom_range(0, 100);
      p1 = (seg % 3 == 0) ? p0 : $urandom_range(0, 100);
      for (int c = 0; c < 64; c++) begin
        bit         rst;
        bit         v0;
        bit         v1;
        logic [7:0] d0;
        logic [7:0] d1;
        rst = ($urandom_range(0, 399) == 0);
        v0  = ($urandom_range(0, 99) < p0);
        v1  = ($urandom_range(0, 99) < p1);
        d0  = 8'($urandom);
        d1  = 8'($urandom);
        step(rst, v0, d0, v1, d1);
        check("rand valid_demux", 32'(valid_demux), 32'(m_valid));
        check("rand data_demux",  32'(data_demux),  32'(m_data));
        check("rand aligned",     32'(aligned),     32'(m_run));
        check("rand overflow",    32'(overflow),    32'(m_ovf));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_unstriping.md
Name: byte_unstriping

Overview:
- Receive-side counterpart of the PHY byte striper: merges two byte lanes (stripe 0, stripe 1) back into one byte stream at clk_2f.
- Each lane feeds a small FIFO that absorbs inter-lane skew and gaps.
- After both lanes hold data, bytes are emitted in strict lane-0, lane-1 alternation. Sits between the lane receivers and the byte demux.

Parameters:
- DATA_W, 8, byte width of lanes and output
- DEPTH, 4, entries per lane FIFO (power of two, >=2)
- IDLE_GAP, 4, consecutive starved cycles in RUN before returning to IDLE

Ports:
- clk_2f  in  1  2x byte clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- data_stripe_0  in  DATA_W  lane 0 byte
- valid_stripe_0  in  1  lane 0 byte valid; each high cycle is one push
- data_stripe_1  in  DATA_W  lane 1 byte
- valid_stripe_1  in  1  lane 1 byte valid
- data_demux  out  DATA_W  merged byte, registered
- valid_demux  out  1  merged byte valid, registered
- aligned  out  1  high while FSM in RUN
- overflow  out  1  sticky: a lane push was dropped on a full FIFO

Behaviour:
- Interface (decided): one clock, clk_2f; reset is synchronous and active-high, port named reset. No asynchronous logic.
- Reset (sampled high on an edge):
  - data_demux=0, valid_demux=0, aligned=0, overflow=0.
  - Both FIFOs empty; sel=0; gap counter=0; FSM=IDLE.
  - Reset mid-stream discards all buffered bytes.
- Lane FIFO:
  - Push when valid_stripe_x=1; pop under FSM control.
  - Push and pop in the same cycle are both legal, including when full or empty.
  - A push on empty FIFO with a simultaneous pop must not bypass: the pop sees empty.
  - A push while full with no pop: byte dropped, overflow set. overflow stays high until reset.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- FSM IDLE:
  - No pops; valid_demux=0.
  - Go to RUN when both FIFOs are non-empty (registered status); sel forced to 0.
- FSM RUN:
  - Each cycle, if FIFO[sel] is non-empty:
    - pop it;
    - data_demux <= head byte; valid_demux <= 1;
    - sel toggles; gap counter clears.
  - Else:
    - valid_demux <= 0;
    - data_demux holds its last value;
    - sel holds (stall, ordering preserved);
    - gap counter increments.
  - If gap counter reaches IDLE_GAP and both FIFOs are empty: go to IDLE, aligned <= 0, sel <= 0.
  - Bytes left in the other FIFO at that time remain and participate in the next alignment.
- Latency: both lanes pushed at edge t0 -> RUN at edge t0+1 -> lane-0 byte on outputs after edge t0+2, lane-1 byte after t0+3.
- Throughput: one byte per cycle when both lanes sustain one push per two cycles.
- Simultaneous push to FIFO[sel] and pop in RUN: the pop takes the older head; the count is unchanged.

Decomposition:
- Shared PHY package:
  - DATA_W default;
  - FSM state encoding (ST_IDLE=1'b0, ST_RUN=1'b1);
  - lane index constants LANE0=0, LANE1=1.
- One sub-module: lane_fifo (DATA_W, DEPTH; push, pop, din, dout, empty, full, drop), instantiated twice.
- Merge FSM, sel, gap counter and output registers live in byte_unstriping.

Test Plan:
- Reset behaviour: hold reset 3 cycles while driving valid_stripe_0/1=1 -> all outputs 0, no pushes retained; aligned=0 one cycle after release.
- Aligned stream: lanes push 0x00,0x02,0x04 / 0x01,0x03,0x05 on the same edges every other cycle -> data_demux 0x00..0x05 consecutive, valid_demux high, first output 2 edges after first push.
- Skew: lane 1 delayed 3 cycles relative to lane 0 (bytes 0xA0,0xA2 / 0xA1,0xA3) -> no output until lane 1 arrives, then 0xA0,0xA1,0xA2,0xA3 in order, overflow=0.
- Overflow: push 5 bytes on lane 0 with lane 1 idle (DEPTH=4) -> overflow=1 after the 5th push and stays 1; aligned=0; after lane 1 pushes, outputs are lane-0 bytes 1-4 interleaved with lane 1.
- Starvation/re-align: mid-stream, stop lane 1 for 6 cycles -> valid_demux=0 while waiting for lane 1, sel held, aligned drops after IDLE_GAP starved cycles once both FIFOs empty, re-aligns starting with lane 0 on resume.
- Reset mid-stream: assert reset with 2 bytes buffered per lane -> next edge all outputs 0, FIFOs empty, no stale bytes emitted after release.
